// File: rtl/emg_adc_capture.sv
// EMG SAR-ADC receive path: deserializes each conversion, tags it with channel/gain, and buffers it in a show-ahead FIFO.
// Optional channel-sequence checking is enabled by defining EMG_CAPTURE_SEQ_CHECK_EN.
module emg_adc_capture #(
    parameter int NUM_CH        = 16,
    parameter int ADC_CLK_CYCLE = 13,
    parameter int ADC_BITS      = 10,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                              ADC_CLK_EMG,
    input  logic                              RESETn,
    input  logic                              EN_ADC_EMG,
    input  logic                              START_EMG,
    input  logic [3:0]                        CH_SEL_EMG,
    input  logic [2:0]                        GAIN_EMG,
    input  logic                              ADC_DOUT,
    input  logic                              RD_READY,
    output logic                              RD_VALID,
    output logic [ADC_BITS+6:0]               RD_DATA,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT,
    output logic                              FRAME_DONE,
    output logic                              OVERFLOW,
    output logic                              PROTO_ERR,
    output logic                              SEQ_ERR,
    input  logic                              CLR_FLAGS
);

    localparam int WORD_W  = ADC_BITS + 7;
    localparam int CNT_W   = $clog2(ADC_CLK_CYCLE);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(ADC_CLK_CYCLE - 1);
    localparam logic [CNT_W-1:0]   FIRST_BIT = CNT_W'(ADC_CLK_CYCLE - ADC_BITS);
    localparam logic [3:0]         LAST_CH   = 4'(NUM_CH - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [3:0]             ch_q;
    logic [2:0]             gain_q;
    logic [ADC_BITS-2:0]    shreg;

    logic [WORD_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [COUNT_W-1:0]     count;

    logic                   start_acc;
    logic                   last_edge;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_ok;
    logic                   overflow_set;
    logic                   proto_set;
    logic [ADC_BITS-1:0]    shreg_next;
    logic [WORD_W-1:0]      push_word;

    // NOTE: combinational logic uses blocking '=' with a default for every signal first,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        start_acc    = 1'b0;
        last_edge    = 1'b0;
        proto_set    = 1'b0;
        shreg_next   = {shreg, ADC_DOUT};
        push_word    = {gain_q, ch_q, shreg_next};
        fifo_full    = (count == FULL_CNT);
        pop          = RD_VALID && RD_READY;
        if (EN_ADC_EMG) begin
            start_acc = (state == IDLE) && START_EMG;
            last_edge = (state == CONV) && (cnt == LAST_CNT);
            proto_set = (state == CONV) && START_EMG;
        end
        push_ok      = last_edge && (!fifo_full || pop);
        overflow_set = last_edge && fifo_full && !pop;
    end

    // NOTE: sequential state is updated with non-blocking '<=' so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge ADC_CLK_EMG or negedge RESETn) begin
        if (!RESETn) begin
            state  <= IDLE;
            cnt    <= '0;
            ch_q   <= '0;
            gain_q <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        ch_q   <= CH_SEL_EMG;
                        gain_q <= GAIN_EMG;
                        cnt    <= CNT_W'(1);
                        state  <= CONV;
                    end
                end
                CONV: begin
                    if (!EN_ADC_EMG || cnt == LAST_CNT) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt >= FIRST_BIT) begin
                            shreg <= shreg_next[ADC_BITS-2:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge ADC_CLK_EMG or negedge RESETn) begin
        if (!RESETn) begin
            FRAME_DONE <= 1'b0;
            OVERFLOW   <= 1'b0;
            PROTO_ERR  <= 1'b0;
        end else begin
            FRAME_DONE <= last_edge && (ch_q == LAST_CH);
            if (overflow_set) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_FLAGS) begin
                OVERFLOW <= 1'b0;
            end
            if (proto_set) begin
                PROTO_ERR <= 1'b1;
            end else if (CLR_FLAGS) begin
                PROTO_ERR <= 1'b0;
            end
        end
    end

`ifdef EMG_CAPTURE_SEQ_CHECK_EN
    logic [3:0] prev_ch;
    logic       have_prev;
    logic [3:0] expect_ch;
    logic       seq_set;

    always_comb begin
        expect_ch = (prev_ch == LAST_CH) ? 4'd0 : prev_ch + 4'd1;
        seq_set   = start_acc && have_prev && (CH_SEL_EMG != expect_ch);
    end

    // Tracking restarts whenever the ADC is disabled, so the first START after that is never flagged.
    always_ff @(posedge ADC_CLK_EMG or negedge RESETn) begin
        if (!RESETn) begin
            prev_ch   <= '0;
            have_prev <= 1'b0;
            SEQ_ERR   <= 1'b0;
        end else begin
            if (!EN_ADC_EMG) begin
                have_prev <= 1'b0;
            end else if (start_acc) begin
                prev_ch   <= CH_SEL_EMG;
                have_prev <= 1'b1;
            end
            if (seq_set) begin
                SEQ_ERR <= 1'b1;
            end else if (CLR_FLAGS) begin
                SEQ_ERR <= 1'b0;
            end
        end
    end
`else
    assign SEQ_ERR = 1'b0;
`endif

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by the
    // reset pointers/count and RD_DATA is gated to zero while the FIFO is empty.
    always_ff @(posedge ADC_CLK_EMG) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge ADC_CLK_EMG or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign RD_VALID   = (count != '0);
    assign RD_DATA    = RD_VALID ? mem[rd_ptr] : '0;
    assign FIFO_COUNT = count;

endmodule

// File: tb/tb_emg_adc_capture.sv
// Directed self-checking bench for emg_adc_capture (default parameters).
// Expected SEQ_ERR follows whether EMG_CAPTURE_SEQ_CHECK_EN is defined for the build.
module tb_emg_adc_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [3:0]  ch_sel;
    logic [2:0]  gain;
    logic        dout;
    logic        rd_ready;
    logic        clr_flags;
    logic        rd_valid;
    logic [16:0] rd_data;
    logic [3:0]  fifo_count;
    logic        frame_done;
    logic        overflow;
    logic        proto_err;
    logic        seq_err;

    int checks   = 0;
    int failures = 0;
    int frame_pulses = 0;
    logic valid_pre_last;

`ifdef EMG_CAPTURE_SEQ_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    emg_adc_capture dut (
        .ADC_CLK_EMG (clk),
        .RESETn      (rst_n),
        .EN_ADC_EMG  (en),
        .START_EMG   (start),
        .CH_SEL_EMG  (ch_sel),
        .GAIN_EMG    (gain),
        .ADC_DOUT    (dout),
        .RD_READY    (rd_ready),
        .RD_VALID    (rd_valid),
        .RD_DATA     (rd_data),
        .FIFO_COUNT  (fifo_count),
        .FRAME_DONE  (frame_done),
        .OVERFLOW    (overflow),
        .PROTO_ERR   (proto_err),
        .SEQ_ERR     (seq_err),
        .CLR_FLAGS   (clr_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] word(input logic [2:0] g, input logic [3:0] c, input logic [9:0] d);
        return {g, c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_done) frame_pulses++;
    endtask

    // One conversion: START at E0, ADC bits on E3..E12. Optional mid-conversion START (proto_j),
    // EN drop (abort_j), early return (stop_j) and a one-edge pop on the final edge (pop_last).
    task automatic conv(input logic [3:0] c, input logic [2:0] g, input logic [9:0] d,
                        input int proto_j, input int abort_j, input int stop_j, input bit pop_last);
        start  = 1'b1;
        ch_sel = c;
        gain   = g;
        tick();
        for (int j = 1; j <= 12; j++) begin
            start = (j == proto_j);
            if (j == proto_j) ch_sel = c + 4'd7;
            if (j >= 3) dout = d[12-j];
            if (j == abort_j) en = 1'b0;
            if (j == 12) begin
                valid_pre_last = rd_valid;
                if (pop_last) rd_ready = 1'b1;
            end
            tick();
            if (j == abort_j) begin
                en    = 1'b1;
                start = 1'b0;
                return;
            end
            if (j == stop_j) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        if (pop_last) rd_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_data"}, 32'(rd_data), 32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_frame"}, 32'(frame_done), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_proto"}, 32'(proto_err), 32'd0);
        check({tag, "_seq"}, 32'(seq_err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; start = 1'b0; ch_sel = '0; gain = '0;
        dout = 1'b0; rd_ready = 1'b0; clr_flags = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Single conversion and latency
        conv(4'd5, 3'b111, 10'h2A5, 0, 0, 0, 1'b0);
        check("single_valid_before_E12", 32'(valid_pre_last), 32'd0);
        check("single_valid", 32'(rd_valid), 32'd1);
        check("single_data", 32'(rd_data), 32'h1D6A5);
        check("single_count", 32'(fifo_count), 32'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("single_pop_count", 32'(fifo_count), 32'd0);
        check("single_pop_valid", 32'(rd_valid), 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("empty_pop_count", 32'(fifo_count), 32'd0);

        // Full frame of 16 back-to-back conversions, consumer always ready
        frame_pulses = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            conv(4'(i), 3'(i), 10'(i * 73 + 5), 0, 0, 0, 1'b0);
            check($sformatf("frame_valid_%0d", i), 32'(rd_valid), 32'd1);
            check($sformatf("frame_data_%0d", i), 32'(rd_data), 32'(word(3'(i), 4'(i), 10'(i * 73 + 5))));
            check($sformatf("frame_count_%0d", i), 32'(fifo_count), 32'd1);
            check($sformatf("frame_done_%0d", i), 32'(frame_done), (i == 15) ? 32'd1 : 32'd0);
        end
        tick();
        rd_ready = 1'b0;
        check("frame_pulses", 32'(frame_pulses), 32'd1);
        check("frame_done_clear", 32'(frame_done), 32'd0);
        check("frame_drained", 32'(fifo_count), 32'd0);
        check("frame_ovf", 32'(overflow), 32'd0);
        check("frame_proto", 32'(proto_err), 32'd0);
        check("frame_seq", 32'(seq_err), 32'd0);

        // Fill, push+pop when full, then overflow
        for (int i = 0; i < 8; i++) conv(4'(i), 3'(i), 10'(i * 29 + 100), 0, 0, 0, 1'b0);
        check("fill_count", 32'(fifo_count), 32'd8);
        check("fill_ovf", 32'(overflow), 32'd0);
        check("fill_head", 32'(rd_data), 32'(word(3'd0, 4'd0, 10'd100)));
        conv(4'd8, 3'd0, 10'(8 * 29 + 100), 0, 0, 0, 1'b1);
        check("full_pushpop_count", 32'(fifo_count), 32'd8);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        conv(4'd9, 3'd1, 10'(9 * 29 + 100), 0, 0, 0, 1'b0);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_head_%0d", i), 32'(rd_data), 32'(word(3'(i), 4'(i), 10'(i * 29 + 100))));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("drain_count", 32'(fifo_count), 32'd0);

        // START during conversion, then EN abort
        conv(4'd10, 3'd2, 10'h3C1, 6, 0, 0, 1'b0);
        check("proto_flag", 32'(proto_err), 32'd1);
        check("proto_word", 32'(rd_data), 32'(word(3'd2, 4'd10, 10'h3C1)));
        check("proto_count", 32'(fifo_count), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("proto_cleared", 32'(proto_err), 32'd0);
        conv(4'd11, 3'd3, 10'h0F0, 0, 8, 0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("abort_count", 32'(fifo_count), 32'd1);
        conv(4'd12, 3'd4, 10'h1E7, 0, 0, 0, 1'b0);
        check("after_abort_count", 32'(fifo_count), 32'd2);
        check("after_abort_proto", 32'(proto_err), 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("after_abort_word", 32'(rd_data), 32'(word(3'd4, 4'd12, 10'h1E7)));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // Channel sequence 3,4,6 after an EN-low restart of tracking
        en = 1'b0;
        tick();
        en = 1'b1;
        conv(4'd3, 3'd1, 10'h011, 0, 0, 0, 1'b0);
        conv(4'd4, 3'd1, 10'h022, 0, 0, 0, 1'b0);
        check("seq_ok_so_far", 32'(seq_err), 32'd0);
        conv(4'd6, 3'd1, 10'h033, 0, 0, 0, 1'b0);
        check("seq_flag", 32'(seq_err), 32'(SEQ_EXP));
        check("seq_count", 32'(fifo_count), 32'd3);
        check("seq_head", 32'(rd_data), 32'(word(3'd1, 4'd3, 10'h011)));

        // Asynchronous reset mid-conversion with three words buffered
        conv(4'd7, 3'd5, 10'h2AA, 0, 0, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        conv(4'd2, 3'd5, 10'h155, 0, 0, 0, 1'b0);
        check("post_reset_count", 32'(fifo_count), 32'd1);
        check("post_reset_word", 32'(rd_data), 32'(word(3'd5, 4'd2, 10'h155)));
        check("post_reset_seq", 32'(seq_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
